// File: rtl/cnn_ctrl_pkg.sv
// Shared types and defaults for the convolution layer control path.
package cnn_ctrl_pkg;

   localparam int DIM_W_DEF      = 8;
   localparam int PIPE_DEPTH_DEF = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      RUN,
      DRAIN,
      DONE
   } state_t;

   typedef struct packed {
      logic [DIM_W_DEF-1:0] row;
      logic [DIM_W_DEF-1:0] col;
      logic [DIM_W_DEF-1:0] oc;
   } coord_t;

endpackage

// File: rtl/conv_pixel_counter.sv
// Row/column raster counter over one output channel; wraps at the latched H-1/W-1.
module conv_pixel_counter
   import cnn_ctrl_pkg::*;
#(
   parameter int DIM_W = DIM_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [DIM_W-1:0] h_m1,
   input  logic [DIM_W-1:0] w_m1,
   output logic [DIM_W-1:0] row,
   output logic [DIM_W-1:0] col,
   output logic             last
);

   assign last = (row == h_m1) && (col == w_m1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
      end else if (clr) begin
         row <= '0;
         col <= '0;
      end else if (en) begin
         if (col == w_m1) begin
            col <= '0;
            row <= (row == h_m1) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Walks output channels: weight load, pixel-coordinate stream, pipeline drain, done pulse.
module conv_layer_sequencer
   import cnn_ctrl_pkg::*;
#(
   parameter int DIM_W      = DIM_W_DEF,
   parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [DIM_W-1:0] cfg_out_h,
   input  logic [DIM_W-1:0] cfg_out_w,
   input  logic [DIM_W-1:0] cfg_out_ch,
   output logic             wload_req,
   output logic [DIM_W-1:0] wload_oc,
   input  logic             wload_done,
   output logic             pe_valid,
   input  logic             pe_ready,
   output logic [DIM_W-1:0] pe_row,
   output logic [DIM_W-1:0] pe_col,
   output logic [DIM_W-1:0] pe_oc,
   output logic             pe_last,
   output logic             busy,
   output logic             done
);

   localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

   state_t               state;
   logic [DIM_W-1:0]     h_m1;
   logic [DIM_W-1:0]     w_m1;
   logic [DIM_W-1:0]     ch_m1;
   logic [DIM_W-1:0]     oc;
   logic [DRAIN_W-1:0]   drain_cnt;
   logic                 cnt_clr;
   logic                 cnt_en;
   logic                 cnt_last;
   logic [DIM_W-1:0]     row;
   logic [DIM_W-1:0]     col;

   // Counters sit at (0,0) outside RUN so each channel starts from the origin
   assign cnt_clr = abort || (state != RUN);
   assign cnt_en  = (state == RUN) && pe_ready;

   conv_pixel_counter #(
      .DIM_W (DIM_W)
   ) u_pix (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .h_m1  (h_m1),
      .w_m1  (w_m1),
      .row   (row),
      .col   (col),
      .last  (cnt_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         h_m1      <= '0;
         w_m1      <= '0;
         ch_m1     <= '0;
         oc        <= '0;
         drain_cnt <= '0;
      end else if (abort) begin
         state     <= IDLE;
         oc        <= '0;
         drain_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  h_m1  <= cfg_out_h - 1'b1;
                  w_m1  <= cfg_out_w - 1'b1;
                  ch_m1 <= cfg_out_ch - 1'b1;
                  oc    <= '0;
                  if ((cfg_out_h == '0) || (cfg_out_w == '0) || (cfg_out_ch == '0))
                     state <= DONE;
                  else
                     state <= LOAD_W;
               end
            end
            LOAD_W: begin
               if (wload_done)
                  state <= RUN;
            end
            RUN: begin
               if (pe_ready && cnt_last) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end
            end
            DRAIN: begin
               if (drain_cnt == DRAIN_W'(PIPE_DEPTH - 1)) begin
                  drain_cnt <= '0;
                  if (oc == ch_m1) begin
                     state <= DONE;
                  end else begin
                     oc    <= oc + 1'b1;
                     state <= LOAD_W;
                  end
               end else begin
                  drain_cnt <= drain_cnt + 1'b1;
               end
            end
            DONE: begin
               oc    <= '0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign wload_req = (state == LOAD_W);
   assign wload_oc  = oc;
   assign pe_valid  = (state == RUN);
   assign pe_last   = (state == RUN) && cnt_last;
   assign pe_row    = row;
   assign pe_col    = col;
   assign pe_oc     = oc;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a raster-order reference model and scoreboard.
module tb_conv_layer_sequencer;
   import cnn_ctrl_pkg::*;

   localparam int DW = 8;
   localparam int PD = 4;

   typedef struct packed {
      coord_t c;
      logic   last;
   } xfer_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [DW-1:0] cfg_out_h = '0;
   logic [DW-1:0] cfg_out_w = '0;
   logic [DW-1:0] cfg_out_ch = '0;
   logic          wload_req;
   logic [DW-1:0] wload_oc;
   logic          wload_done;
   logic          pe_valid;
   logic          pe_ready;
   logic [DW-1:0] pe_row;
   logic [DW-1:0] pe_col;
   logic [DW-1:0] pe_oc;
   logic          pe_last;
   logic          busy;
   logic          done;

   conv_layer_sequencer #(.DIM_W(DW), .PIPE_DEPTH(PD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .cfg_out_h  (cfg_out_h),
      .cfg_out_w  (cfg_out_w),
      .cfg_out_ch (cfg_out_ch),
      .wload_req  (wload_req),
      .wload_oc   (wload_oc),
      .wload_done (wload_done),
      .pe_valid   (pe_valid),
      .pe_ready   (pe_ready),
      .pe_row     (pe_row),
      .pe_col     (pe_col),
      .pe_oc      (pe_oc),
      .pe_last    (pe_last),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            failures = 0;
   xfer_t         exp_x[$];
   logic [DW-1:0] exp_ld[$];
   int            xfer_cnt = 0;
   int            load_cnt = 0;
   int            done_cnt = 0;
   int            idle_cnt = 0;
   bit            have_last = 0;
   bit            auto_wl = 1;
   bit            spurious_wl = 0;
   bit            tog_mode = 0;
   int            wl_age = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Weight loader: answers each request 2 cycles after it rises
   initial begin
      wload_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (wload_req && auto_wl) wl_age++;
         else wl_age = 0;
         wload_done = (wl_age == 3) || spurious_wl;
      end
   end

   initial begin
      pe_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         pe_ready = tog_mode ? ~pe_ready : 1'b1;
      end
   end

   // Scoreboard
   logic          prev_req = 0, prev_hold = 0, prev_done = 0;
   logic [DW-1:0] hr, hc, ho, hld_oc;
   logic          hl;
   xfer_t         e_x;
   logic [DW-1:0] e_ld;

   always @(negedge clk) begin
      if (rst_n) begin
         if (pe_valid && pe_ready) begin
            xfer_cnt++;
            if (exp_x.size() == 0) begin
               chk("unexpected_xfer", 1, 0);
            end else begin
               e_x = exp_x.pop_front();
               chk("xfer_row", pe_row, e_x.c.row);
               chk("xfer_col", pe_col, e_x.c.col);
               chk("xfer_oc", pe_oc, e_x.c.oc);
               chk("xfer_last", pe_last, e_x.last);
            end
            if (pe_last) begin
               have_last = 1;
               idle_cnt  = 0;
            end
         end else if (busy && !pe_valid && !wload_req) begin
            idle_cnt++;
         end
         if (prev_hold && pe_valid) begin
            chk("hold_row", pe_row, hr);
            chk("hold_col", pe_col, hc);
            chk("hold_oc", pe_oc, ho);
            chk("hold_last", pe_last, hl);
         end
         prev_hold = pe_valid && !pe_ready;
         hr = pe_row; hc = pe_col; ho = pe_oc; hl = pe_last;
         if (wload_req && !prev_req) begin
            load_cnt++;
            if (exp_ld.size() == 0) begin
               chk("unexpected_load", 1, 0);
            end else begin
               e_ld = exp_ld.pop_front();
               chk("wload_oc", wload_oc, e_ld);
            end
            if (have_last) chk("drain_gap", idle_cnt, PD);
         end else if (wload_req && prev_req) begin
            chk("wload_oc_stable", wload_oc, hld_oc);
         end
         hld_oc = wload_oc;
         if (prev_done) chk("busy_after_done", busy, 0);
         if (done) begin
            done_cnt++;
            have_last = 0;
         end
         prev_req  = wload_req;
         prev_done = done;
      end else begin
         prev_req  = 0;
         prev_hold = 0;
         prev_done = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cfg(input int h, input int w, input int ch);
      cfg_out_h  = DW'(h);
      cfg_out_w  = DW'(w);
      cfg_out_ch = DW'(ch);
   endtask

   task automatic model_layer(input int h, input int w, input int ch);
      xfer_t t;
      for (int o = 0; o < ch; o++) begin
         exp_ld.push_back(DW'(o));
         for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
               t.c.row = DW'(r);
               t.c.col = DW'(c);
               t.c.oc  = DW'(o);
               t.last  = (r == h - 1) && (c == w - 1);
               exp_x.push_back(t);
            end
      end
   endtask

   task automatic flush();
      exp_x.delete();
      exp_ld.delete();
      have_last = 0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (done !== 1'b1 && n < budget) begin
         tick();
         n++;
      end
      chk(name, (n < budget) ? 1 : 0, 1);
   endtask

   task automatic chk_all_zero(input string pfx);
      chk({pfx, "_busy"}, busy, 0);
      chk({pfx, "_done"}, done, 0);
      chk({pfx, "_wload_req"}, wload_req, 0);
      chk({pfx, "_wload_oc"}, wload_oc, 0);
      chk({pfx, "_pe_valid"}, pe_valid, 0);
      chk({pfx, "_pe_last"}, pe_last, 0);
      chk({pfx, "_pe_row"}, pe_row, 0);
      chk({pfx, "_pe_col"}, pe_col, 0);
      chk({pfx, "_pe_oc"}, pe_oc, 0);
   endtask

   int xb, lb, db, n;

   initial begin
      repeat (3) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Two channels of 2x3, ready always high
      flush();
      model_layer(2, 3, 2);
      chk("model_len", exp_x.size(), 12);
      e_x = exp_x[5];
      chk("model_6th_row", e_x.c.row, 1);
      chk("model_6th_col", e_x.c.col, 2);
      chk("model_6th_last", e_x.last, 1);
      e_x = exp_x[11];
      chk("model_12th_oc", e_x.c.oc, 1);
      chk("model_12th_last", e_x.last, 1);
      xb = xfer_cnt; lb = load_cnt; db = done_cnt;
      set_cfg(2, 3, 2);
      start = 1'b1;
      @(negedge clk);
      chk("lat1_wload_req", wload_req, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("lat2_wload_req", wload_req, 1);
      wait_done("t1_done_seen", 300);
      tick();
      chk("t1_busy_low", busy, 0);
      chk("t1_xfers", xfer_cnt - xb, 12);
      chk("t1_loads", load_cnt - lb, 2);
      chk("t1_dones", done_cnt - db, 1);
      chk("t1_queue_empty", exp_x.size(), 0);

      // Backpressure with toggling ready
      flush();
      model_layer(1, 2, 1);
      xb = xfer_cnt;
      set_cfg(1, 2, 1);
      tog_mode = 1;
      pulse_start();
      wait_done("t2_done_seen", 100);
      tick();
      tog_mode = 0;
      chk("t2_xfers", xfer_cnt - xb, 2);
      chk("t2_queue_empty", exp_x.size(), 0);

      // Zero width: straight to DONE
      flush();
      xb = xfer_cnt; lb = load_cnt; db = done_cnt;
      set_cfg(2, 0, 2);
      start = 1'b1;
      @(negedge clk);
      chk("zero_lat1_done", done, 0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("zero_lat2_done", done, 1);
      tick();
      tick();
      chk("zero_loads", load_cnt - lb, 0);
      chk("zero_xfers", xfer_cnt - xb, 0);
      chk("zero_dones", done_cnt - db, 1);

      // Abort on the third transfer
      flush();
      model_layer(2, 3, 1);
      xb = xfer_cnt; db = done_cnt;
      set_cfg(2, 3, 1);
      pulse_start();
      n = 0;
      while (xfer_cnt < xb + 2 && n < 100) begin
         tick();
         n++;
      end
      chk("abort_reach_xfer3", (n < 100) ? 1 : 0, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_all_zero("abort");
      flush();
      repeat (10) tick();
      chk("abort_no_done", done_cnt - db, 0);
      chk("abort_xfers", xfer_cnt - xb, 3);
      model_layer(1, 1, 1);
      xb = xfer_cnt;
      set_cfg(1, 1, 1);
      pulse_start();
      wait_done("after_abort_done_seen", 100);
      tick();
      chk("after_abort_xfers", xfer_cnt - xb, 1);
      chk("after_abort_queue_empty", exp_x.size(), 0);

      // Reset during LOAD_W, then a stale wload_done
      auto_wl = 0;
      flush();
      model_layer(2, 2, 1);
      set_cfg(2, 2, 1);
      pulse_start();
      n = 0;
      while (wload_req !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("rst_reach_load", (n < 20) ? 1 : 0, 1);
      tick();
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      tick();
      rst_n = 1'b1;
      flush();
      xb = xfer_cnt; lb = load_cnt; db = done_cnt;
      tick();
      spurious_wl = 1;
      tick();
      tick();
      spurious_wl = 0;
      tick();
      tick();
      chk_all_zero("rst_stale");
      chk("rst_stale_loads", load_cnt - lb, 0);
      chk("rst_stale_xfers", xfer_cnt - xb, 0);
      auto_wl = 1;
      tick();

      // Start during RUN is ignored
      flush();
      model_layer(2, 2, 1);
      xb = xfer_cnt; lb = load_cnt; db = done_cnt;
      set_cfg(2, 2, 1);
      pulse_start();
      n = 0;
      while (pe_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk("ign_reach_run", (n < 20) ? 1 : 0, 1);
      set_cfg(7, 7, 7);
      pulse_start();
      wait_done("ign_done_seen", 100);
      tick();
      chk("ign_xfers", xfer_cnt - xb, 4);
      chk("ign_loads", load_cnt - lb, 1);
      chk("ign_dones", done_cnt - db, 1);
      chk("ign_queue_empty", exp_x.size(), 0);

      // Start together with abort in IDLE
      flush();
      xb = xfer_cnt; lb = load_cnt; db = done_cnt;
      set_cfg(1, 1, 1);
      start = 1'b1;
      abort = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      repeat (5) tick();
      chk("sa_busy", busy, 0);
      chk("sa_xfers", xfer_cnt - xb, 0);
      chk("sa_loads", load_cnt - lb, 0);
      chk("sa_dones", done_cnt - db, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
